// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared types and default constants for the UART command-framing slice.
//   cmd_state_t   : framing FSM states (IDLE, COLLECT, HOLD)
//   CMD_BYTES     : default number of bytes per command
//   BIT_CLKS      : default clocks per UART bit
//   TIMEOUT_CLKS  : default inter-byte timeout, two 10-bit byte times
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } cmd_state_t;

  localparam int CMD_BYTES    = 3;
  localparam int BIT_CLKS     = 2604;
  localparam int TIMEOUT_CLKS = 2 * 10 * BIT_CLKS;

endpackage

// File: rtl/cmd_timeout_timer.sv
// cmd_timeout_timer
//   Inter-byte gap timer for the command framer. Counts while enabled and
//   sticks at TIMEOUT-1 instead of wrapping, so a stalled frame keeps
//   reporting expiry until something clears the timer.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clr     : synchronous clear back to zero (wins over en)
//   en      : count enable
//   expired : combinational, high while count == TIMEOUT-1
module cmd_timeout_timer #(
  parameter int TIMEOUT = uart_cmd_pkg::TIMEOUT_CLKS
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Gap counter: clear has priority, and counting stops at the expiry
  // value so the counter saturates rather than wrapping to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Packs the UART receiver byte stream into fixed-length commands, first
//   byte in the MSBs, and holds each finished command until acknowledged.
//   A partial frame is discarded when the gap between bytes gets too long,
//   and bytes that arrive while a command is still held are dropped.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   rx_rdy      : one-cycle strobe, rx_data is valid
//   rx_data     : received byte
//   clr_cmd_rdy : consumer acknowledge, releases the held command
//   cmd         : assembled command (8*NUM_BYTES bits)
//   cmd_rdy     : a complete command is held on cmd
//   frame_err   : one-cycle pulse, partial frame dropped on timeout
//   overrun     : one-cycle pulse, byte dropped while cmd_rdy was held
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int NUM_BYTES = CMD_BYTES,
  parameter int TIMEOUT   = TIMEOUT_CLKS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  input  logic                   clr_cmd_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int CMD_W = 8 * NUM_BYTES;
  localparam int IW    = $clog2(NUM_BYTES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  cmd_state_t    state;
  logic [IW-1:0] idx;
  logic          expired;
  logic          timer_clr;

  // The timer only runs while a frame is being collected; any strobe
  // restarts the gap measurement, and outside COLLECT it is held at zero
  // so a new frame always starts with a full timeout window.
  assign timer_clr = rx_rdy || (state != COLLECT);

  cmd_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (state == COLLECT),
    .expired(expired)
  );

  // Framing FSM with registered outputs. The pulse outputs default low
  // every cycle. In COLLECT a strobe is checked before expiry so a byte
  // landing on the timeout cycle is still accepted. In HOLD an ack plus
  // a strobe in the same cycle starts the next frame directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            cmd   <= {cmd[CMD_W-9:0], rx_data};
            idx   <= IW'(1);
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (rx_rdy) begin
            cmd <= {cmd[CMD_W-9:0], rx_data};
            if (idx == LAST_IDX) begin
              idx     <= '0;
              cmd_rdy <= 1'b1;
              state   <= HOLD;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (expired) begin
            frame_err <= 1'b1;
            idx       <= '0;
            state     <= IDLE;
          end
        end
        HOLD: begin
          if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
            if (rx_rdy) begin
              cmd   <= {cmd[CMD_W-9:0], rx_data};
              idx   <= IW'(1);
              state <= COLLECT;
            end else begin
              state <= IDLE;
            end
          end else if (rx_rdy) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
//   Directed bench for uart_cmd_ctrl with a short timeout so every
//   scenario fits in a few hundred clocks. A frame-level model tracks the
//   expected outputs and is compared every cycle; literal expectations
//   at key points pin the model to hand-computed values.
module tb_uart_cmd_ctrl;

  localparam int NB    = 3;
  localparam int TO    = 40;
  localparam int GAP   = TO / 2;
  localparam int CMD_W = 8 * NB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_rdy = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             clr_cmd_rdy = 1'b0;
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             frame_err;
  logic             overrun;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  uart_cmd_ctrl #(
    .NUM_BYTES(NB),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Frame-level model: a queue of bytes collected so far, the cycle of
  // the last accepted byte and a held flag. Outputs follow from those.
  logic [7:0]       frame[$];
  int               cyc = 0;
  int               accCyc = 0;
  bit               mHold = 1'b0;
  bit               mRdy = 1'b0;
  bit               mFerr = 1'b0;
  bit               mOvr = 1'b0;
  bit               cmdKnown = 1'b1;
  logic [CMD_W-1:0] mCmd = '0;

  function automatic logic [CMD_W-1:0] packFrame();
    logic [CMD_W-1:0] v = '0;
    foreach (frame[i]) v = (v << 8) | CMD_W'(frame[i]);
    return v;
  endfunction

  // Model update on each active edge, using the inputs the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      frame.delete();
      mHold = 0; mRdy = 0; mFerr = 0; mOvr = 0;
      mCmd = '0; cmdKnown = 1;
    end else begin
      mFerr = 0;
      mOvr  = 0;
      if (mHold) begin
        if (clr_cmd_rdy) begin
          mHold = 0;
          mRdy  = 0;
          if (rx_rdy) begin
            frame.push_back(rx_data);
            accCyc = cyc;
            cmdKnown = 0;
          end
        end else if (rx_rdy) begin
          mOvr = 1;
        end
      end else if (frame.size() == 0) begin
        if (rx_rdy) begin
          frame.push_back(rx_data);
          accCyc = cyc;
          cmdKnown = 0;
        end
      end else begin
        if (rx_rdy) begin
          frame.push_back(rx_data);
          accCyc = cyc;
          if (frame.size() == NB) begin
            mCmd = packFrame();
            mRdy = 1;
            mHold = 1;
            cmdKnown = 1;
            frame.delete();
          end
        end else if (cyc - accCyc == TO) begin
          mFerr = 1;
          frame.delete();
        end
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model cmd_rdy", 32'(cmd_rdy), 32'(mRdy));
      checkOutput("model frame_err", 32'(frame_err), 32'(mFerr));
      checkOutput("model overrun", 32'(overrun), 32'(mOvr));
      if (cmdKnown) checkOutput("model cmd", 32'(cmd), 32'(mCmd));
    end
  end

  // Drive one cycle of inputs; they are sampled at the next edge and the
  // task returns just after that edge with inputs back at rest.
  task automatic applyStimulus(input bit rx, input logic [7:0] data, input bit clr);
    rx_rdy      = rx;
    rx_data     = data;
    clr_cmd_rdy = clr;
    @(posedge clk);
    #1;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    doReset();
    checkEn = 1'b1;
    checkOutput("reset cmd", 32'(cmd), 32'h0);
    checkOutput("reset cmd_rdy", 32'(cmd_rdy), 32'h0);
    checkOutput("reset pulses", {30'h0, frame_err, overrun}, 32'h0);

    // Spaced frame
    applyStimulus(1, 8'hA5, 0);
    idleCycles(GAP - 1);
    applyStimulus(1, 8'h3C, 0);
    idleCycles(GAP - 1);
    applyStimulus(1, 8'h7E, 0);
    checkOutput("spaced cmd", 32'(cmd), 32'hA53C7E);
    checkOutput("spaced cmd_rdy", 32'(cmd_rdy), 32'h1);
    checkOutput("spaced frame_err", 32'(frame_err), 32'h0);

    // Overrun while held
    applyStimulus(1, 8'hFF, 0);
    checkOutput("overrun pulse", 32'(overrun), 32'h1);
    checkOutput("overrun cmd frozen", 32'(cmd), 32'hA53C7E);
    idleCycles(1);
    checkOutput("overrun one cycle", 32'(overrun), 32'h0);

    // Ack and new byte together
    applyStimulus(1, 8'h55, 1);
    checkOutput("ack+byte cmd_rdy", 32'(cmd_rdy), 32'h0);
    checkOutput("ack+byte overrun", 32'(overrun), 32'h0);
    applyStimulus(1, 8'h66, 0);
    applyStimulus(1, 8'h77, 0);
    checkOutput("ack+byte cmd", 32'(cmd), 32'h556677);
    applyStimulus(0, 8'h00, 1);
    checkOutput("ack cmd_rdy", 32'(cmd_rdy), 32'h0);

    // Timeout discards a partial frame
    applyStimulus(1, 8'h11, 0);
    idleCycles(GAP - 1);
    applyStimulus(1, 8'h22, 0);
    idleCycles(TO - 1);
    checkOutput("timeout early", 32'(frame_err), 32'h0);
    idleCycles(1);
    checkOutput("timeout pulse", 32'(frame_err), 32'h1);
    checkOutput("timeout cmd_rdy", 32'(cmd_rdy), 32'h0);
    idleCycles(1);
    checkOutput("timeout one cycle", 32'(frame_err), 32'h0);
    applyStimulus(1, 8'h01, 0);
    applyStimulus(1, 8'h02, 0);
    applyStimulus(1, 8'h03, 0);
    checkOutput("after timeout cmd", 32'(cmd), 32'h010203);
    applyStimulus(0, 8'h00, 1);

    // Byte lands on the expiry cycle, then a back-to-back byte
    applyStimulus(1, 8'h10, 0);
    idleCycles(TO - 1);
    applyStimulus(1, 8'h20, 0);
    checkOutput("edge frame_err", 32'(frame_err), 32'h0);
    applyStimulus(1, 8'h30, 0);
    checkOutput("edge cmd", 32'(cmd), 32'h102030);
    checkOutput("edge cmd_rdy", 32'(cmd_rdy), 32'h1);
    applyStimulus(0, 8'h00, 1);

    // Three consecutive strobes
    applyStimulus(1, 8'hDE, 0);
    applyStimulus(1, 8'hAD, 0);
    applyStimulus(1, 8'hBE, 0);
    checkOutput("b2b cmd", 32'(cmd), 32'hDEADBE);
    checkOutput("b2b cmd_rdy", 32'(cmd_rdy), 32'h1);
    applyStimulus(0, 8'h00, 1);

    // Ack outside HOLD is ignored (in IDLE and mid-frame)
    applyStimulus(0, 8'h00, 1);
    applyStimulus(1, 8'h9A, 0);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(1, 8'hBC, 0);
    applyStimulus(1, 8'hDE, 0);
    checkOutput("stray ack cmd", 32'(cmd), 32'h9ABCDE);
    checkOutput("stray ack cmd_rdy", 32'(cmd_rdy), 32'h1);
    applyStimulus(0, 8'h00, 1);

    // Reset mid-frame
    applyStimulus(1, 8'h01, 0);
    applyStimulus(1, 8'h02, 0);
    doReset();
    checkOutput("midreset cmd", 32'(cmd), 32'h0);
    checkOutput("midreset outputs", {29'h0, cmd_rdy, frame_err, overrun}, 32'h0);
    applyStimulus(1, 8'hC0, 0);
    applyStimulus(1, 8'hFF, 0);
    applyStimulus(1, 8'hEE, 0);
    checkOutput("post reset cmd", 32'(cmd), 32'hC0FFEE);
    checkOutput("post reset cmd_rdy", 32'(cmd_rdy), 32'h1);

    // Reset while held
    doReset();
    checkOutput("hold reset", {cmd, cmd_rdy}, 32'h0);
    idleCycles(2);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
